// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dds_sweep_ctrl
// Description : Linear frequency-sweep sequencer for the DDS DAC core.
//               It accepts one sweep command over a valid/ready port. It then
//               steps the frequency word from the start value by a signed
//               increment. Each value is held for (dwell+1) clock cycles. The
//               sweep can run once or repeat, and abort stops it.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               cfg_valid/cfg_ready   - command handshake (ready only in IDLE)
//               cfg_start_fw, cfg_step_fw, cfg_steps, cfg_dwell, cfg_pha,
//               cfg_repeat            - sweep command fields
//               abort                 - terminate a running sweep
//               fre_word, pha_word    - tuning words to the DAC core
//               busy                  - sweep in progress
//               step_pulse            - fre_word changed inside RUN
//               done_pulse            - single-shot sweep finished
// Revision    : 1.0 - initial release
// ============================================================================
module dds_sweep_ctrl #(
  parameter int FW_W    = 32,
  parameter int STEP_W  = 16,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [FW_W-1:0]    cfg_start_fw,
  input  logic [FW_W-1:0]    cfg_step_fw,
  input  logic [STEP_W-1:0]  cfg_steps,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [FW_W-1:0]    cfg_pha,
  input  logic               cfg_repeat,
  input  logic               abort,
  output logic [FW_W-1:0]    fre_word,
  output logic [FW_W-1:0]    pha_word,
  output logic               busy,
  output logic               step_pulse,
  output logic               done_pulse
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [STEP_W-1:0]  C_IDX_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] C_DCNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [FW_W-1:0]    fre_q, fre_d;
  logic [FW_W-1:0]    pha_q, pha_d;
  logic [FW_W-1:0]    start_q, start_d;
  logic [FW_W-1:0]    step_q, step_d;
  logic [STEP_W-1:0]  steps_q, steps_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               rep_q, rep_d;
  logic [STEP_W-1:0]  idx_q, idx_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic               step_pulse_q, step_pulse_d;
  logic               done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fre_q        <= '0;
      pha_q        <= '0;
      start_q      <= '0;
      step_q       <= '0;
      steps_q      <= '0;
      dwell_q      <= '0;
      rep_q        <= 1'b0;
      idx_q        <= '0;
      dcnt_q       <= '0;
      step_pulse_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fre_q        <= fre_d;
      pha_q        <= pha_d;
      start_q      <= start_d;
      step_q       <= step_d;
      steps_q      <= steps_d;
      dwell_q      <= dwell_d;
      rep_q        <= rep_d;
      idx_q        <= idx_d;
      dcnt_q       <= dcnt_d;
      step_pulse_q <= step_pulse_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fre_d        = fre_q;
    pha_d        = pha_q;
    start_d      = start_q;
    step_d       = step_q;
    steps_d      = steps_q;
    dwell_d      = dwell_q;
    rep_d        = rep_q;
    idx_d        = idx_q;
    dcnt_d       = dcnt_q;
    step_pulse_d = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort has no meaning here, so a command arriving together with
        // abort is simply accepted.
        if (cfg_valid) begin
          start_d = cfg_start_fw;
          step_d  = cfg_step_fw;
          steps_d = cfg_steps;
          dwell_d = cfg_dwell;
          rep_d   = cfg_repeat;
          fre_d   = cfg_start_fw;
          pha_d   = cfg_pha;
          idx_d   = '0;
          dcnt_d  = cfg_dwell;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          fre_d   = '0;
        end else if (dcnt_q != '0) begin
          dcnt_d = dcnt_q - C_DCNT_ONE;
        end else if (idx_q != steps_q) begin
          // Modular add: a negative step in two's complement decrements.
          fre_d        = fre_q + step_q;
          idx_d        = idx_q + C_IDX_ONE;
          dcnt_d       = dwell_q;
          step_pulse_d = 1'b1;
        end else if (rep_q) begin
          fre_d        = start_q;
          idx_d        = '0;
          dcnt_d       = dwell_q;
          step_pulse_d = 1'b1;
        end else begin
          // The final word stays on the DAC after a single-shot sweep.
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_ready  = (state_q == S_IDLE);
  assign busy       = (state_q == S_RUN);
  assign fre_word   = fre_q;
  assign pha_word   = pha_q;
  assign step_pulse = step_pulse_q;
  assign done_pulse = done_q;

endmodule
`default_nettype wire
